// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive checker: segment codes, FSM state encoding and the
// BCD successor helper.
package seg7_pkg;

    localparam logic [7:0] SEG7_D0      = 8'hFC;
    localparam logic [7:0] SEG7_D1      = 8'h60;
    localparam logic [7:0] SEG7_D2      = 8'hDA;
    localparam logic [7:0] SEG7_D3      = 8'hF2;
    localparam logic [7:0] SEG7_D4      = 8'h66;
    localparam logic [7:0] SEG7_D5      = 8'hB6;
    localparam logic [7:0] SEG7_D6      = 8'hBE;
    localparam logic [7:0] SEG7_D7      = 8'hE0;
    localparam logic [7:0] SEG7_D8      = 8'hFE;
    localparam logic [7:0] SEG7_D9      = 8'hE6;
    localparam logic [7:0] SEG7_BLANK   = 8'h00;
    localparam logic [7:0] SEG7_DP_MASK = 8'hFE;

    typedef logic [1:0] seg7_state_t;

    localparam seg7_state_t S_IDLE  = 2'd0;
    localparam seg7_state_t S_TRACK = 2'd1;
    localparam seg7_state_t S_ERR   = 2'd2;

    function automatic logic [3:0] seg7_next(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_rx_checker_if.sv
// Display-bus bundle seen by the receive checker. Optional digit_ascii exists only when
// SEG7_ASCII_EN is defined.
interface seg7_rx_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic [7:0]       seg_in;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             bad_code;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
`ifdef SEG7_ASCII_EN
    logic [7:0]       digit_ascii;
`endif

    modport master (
        output seg_in,
        input  digit, digit_valid, bad_code, seq_err, locked, err_cnt
`ifdef SEG7_ASCII_EN
        , input digit_ascii
`endif
    );

    modport slave (
        input  seg_in,
        output digit, digit_valid, bad_code, seq_err, locked, err_cnt
`ifdef SEG7_ASCII_EN
        , output digit_ascii
`endif
    );

endinterface

// File: rtl/seg7_decode_lut.sv
// Combinational segment-pattern decoder: classifies a pattern as a BCD digit, blank, or neither.
module seg7_decode_lut
    import seg7_pkg::*;
(
    input  logic [7:0] pattern_i,
    output logic       is_digit_o,
    output logic       is_blank_o,
    output logic [3:0] digit_o
);

    always_comb begin
        is_digit_o = 1'b1;
        is_blank_o = 1'b0;
        digit_o    = 4'd0;
        case (pattern_i & SEG7_DP_MASK)
            SEG7_D0:    digit_o = 4'd0;
            SEG7_D1:    digit_o = 4'd1;
            SEG7_D2:    digit_o = 4'd2;
            SEG7_D3:    digit_o = 4'd3;
            SEG7_D4:    digit_o = 4'd4;
            SEG7_D5:    digit_o = 4'd5;
            SEG7_D6:    digit_o = 4'd6;
            SEG7_D7:    digit_o = 4'd7;
            SEG7_D8:    digit_o = 4'd8;
            SEG7_D9:    digit_o = 4'd9;
            SEG7_BLANK: begin
                is_digit_o = 1'b0;
                is_blank_o = 1'b1;
            end
            default:    is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_rx_checker.sv
// In-system monitor for the 7-segment bus: debounce, decode, check 0..9 wrap order, count errors.
// Optional feature: SEG7_ASCII_EN adds a registered ASCII copy of the digit.
module seg7_rx_checker
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic          clk,
    input  logic          rst,
    seg7_rx_checker_if.slave bus
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    logic [7:0]       seg_m;
    logic [7:0]       sample_q;
    logic [CntW-1:0]  stab_cnt_q, stab_cnt_d;
    logic [7:0]       last_acc_q, last_acc_d;
    seg7_state_t      state_q, state_d;
    logic [3:0]       exp_q, exp_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             bad_q, bad_d;
    logic             seq_q, seq_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_inc;
    logic             accept;
    logic             is_digit, is_blank;
    logic [3:0]       dec_digit;

    assign seg_m = bus.seg_in & SEG7_DP_MASK;

    seg7_decode_lut u_lut (
        .pattern_i  (seg_m),
        .is_digit_o (is_digit),
        .is_blank_o (is_blank),
        .digit_o    (dec_digit)
    );

    // Count saturates at CntMax; a held pattern is kept from re-firing by last_acc_q.
    always_comb begin
        if (seg_m == sample_q) begin
            stab_cnt_d = (stab_cnt_q == CntMax) ? CntMax : stab_cnt_q + CntW'(1);
        end else begin
            stab_cnt_d = CntW'(1);
        end
        accept = (stab_cnt_d == CntMax) && (seg_m != last_acc_q);
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        digit_d    = digit_q;
        last_acc_d = last_acc_q;
        valid_d    = 1'b0;
        bad_d      = 1'b0;
        seq_d      = 1'b0;
        err_inc    = 1'b0;
        if (accept) begin
            last_acc_d = seg_m;
            if (is_blank) begin
                state_d = S_IDLE;
            end else if (is_digit) begin
                digit_d = dec_digit;
                valid_d = 1'b1;
                exp_d   = seg7_next(dec_digit);
                state_d = S_TRACK;
                if (state_q == S_TRACK && dec_digit != exp_q) begin
                    seq_d   = 1'b1;
                    err_inc = 1'b1;
                    state_d = S_ERR;
                end
            end else begin
                bad_d   = 1'b1;
                err_inc = 1'b1;
                if (state_q == S_TRACK) begin
                    state_d = S_ERR;
                end
            end
        end
        err_d = (err_inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q   <= 8'h00;
            stab_cnt_q <= '0;
            last_acc_q <= SEG7_BLANK;
            state_q    <= S_IDLE;
            exp_q      <= 4'd0;
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            bad_q      <= 1'b0;
            seq_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            sample_q   <= seg_m;
            stab_cnt_q <= stab_cnt_d;
            last_acc_q <= last_acc_d;
            state_q    <= state_d;
            exp_q      <= exp_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            bad_q      <= bad_d;
            seq_q      <= seq_d;
            err_q      <= err_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.bad_code    = bad_q;
    assign bus.seq_err     = seq_q;
    assign bus.locked      = (state_q == S_TRACK);
    assign bus.err_cnt     = err_q;

`ifdef SEG7_ASCII_EN
    logic [7:0] ascii_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_q <= 8'h30;
        end else begin
            ascii_q <= 8'h30 + {4'h0, digit_d};
        end
    end

    assign bus.digit_ascii = ascii_q;
`endif

endmodule

// File: tb/tb_seg7_rx_checker.sv
// Bench for seg7_rx_checker: three configurations share one stimulus stream and are checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_seg7_rx_checker;

    localparam int MIdle  = 0;
    localparam int MTrack = 1;
    localparam int MErr   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg = 8'h00;

    always #5 clk = ~clk;

    seg7_rx_checker_if #(.ERR_W(8)) if0 ();
    seg7_rx_checker_if #(.ERR_W(8)) if1 ();
    seg7_rx_checker_if #(.ERR_W(2)) if2 ();

    assign if0.seg_in = seg;
    assign if1.seg_in = seg;
    assign if2.seg_in = seg;

    seg7_rx_checker #(.STABLE_CYCLES(1), .ERR_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seg7_rx_checker #(.STABLE_CYCLES(3), .ERR_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seg7_rx_checker #(.STABLE_CYCLES(1), .ERR_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Packed view: {digit[15:12], valid[11], bad[10], seq[9], locked[8], err_cnt[7:0]}
    logic [15:0] act [3];
    assign act[0] = {if0.digit, if0.digit_valid, if0.bad_code, if0.seq_err, if0.locked,
                     if0.err_cnt};
    assign act[1] = {if1.digit, if1.digit_valid, if1.bad_code, if1.seq_err, if1.locked,
                     if1.err_cnt};
    assign act[2] = {if2.digit, if2.digit_valid, if2.bad_code, if2.seq_err, if2.locked,
                     6'd0, if2.err_cnt};

    int total = 0;
    int bad   = 0;

    logic [7:0] codes [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};
    int stab [3] = '{1, 3, 1};
    int emax [3] = '{255, 255, 3};

    int m_prev [3];
    int m_run  [3];
    int m_last [3];
    int m_st   [3];
    int m_exp  [3];
    int m_dig  [3];
    int m_err  [3];
    bit m_dv   [3];
    bit m_bc   [3];
    bit m_se   [3];
    bit started = 1'b0;
    int dv_cnt [3] = '{0, 0, 0};

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int lookup(input int m);
        for (int i = 0; i < 10; i++) begin
            if (int'(codes[i]) == m) return i;
        end
        return -1;
    endfunction

    task automatic bump(input int k);
        if (m_err[k] < emax[k]) m_err[k]++;
    endtask

    task automatic model_step(input int k, input int m);
        int d;
        m_dv[k] = 1'b0;
        m_bc[k] = 1'b0;
        m_se[k] = 1'b0;
        if (m == m_prev[k]) m_run[k]++;
        else m_run[k] = 1;
        m_prev[k] = m;
        if (m_run[k] < stab[k] || m == m_last[k]) return;
        m_last[k] = m;
        d = lookup(m);
        if (m == 0) begin
            m_st[k] = MIdle;
        end else if (d < 0) begin
            m_bc[k] = 1'b1;
            bump(k);
            if (m_st[k] == MTrack) m_st[k] = MErr;
        end else begin
            m_dig[k] = d;
            m_dv[k]  = 1'b1;
            if (m_st[k] == MTrack && d != m_exp[k]) begin
                m_se[k] = 1'b1;
                bump(k);
                m_st[k] = MErr;
            end else begin
                m_exp[k] = (d + 1) % 10;
                m_st[k]  = MTrack;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_prev[k] = 0; m_run[k] = 0; m_last[k] = 0; m_st[k] = MIdle;
                m_exp[k]  = 0; m_dig[k] = 0; m_err[k]  = 0;
                m_dv[k]   = 1'b0; m_bc[k] = 1'b0; m_se[k] = 1'b0;
            end else begin
                model_step(k, int'(seg & 8'hFE));
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                logic [15:0] e;
                e = {4'(m_dig[k]), m_dv[k], m_bc[k], m_se[k], (m_st[k] == MTrack),
                     8'(m_err[k])};
                check($sformatf("model_u%0d", k), int'(act[k]), int'(e));
                if (act[k][9] && act[k][10]) check($sformatf("excl_u%0d", k), 1, 0);
                if (act[k][11]) dv_cnt[k]++;
            end
`ifdef SEG7_ASCII_EN
            check("ascii_u0", int'(if0.digit_ascii), 8'h30 + m_dig[0]);
            check("ascii_u1", int'(if1.digit_ascii), 8'h30 + m_dig[1]);
            check("ascii_u2", int'(if2.digit_ascii), 8'h30 + m_dig[2]);
`endif
        end
    end

    // Each call leaves time just past the negedge, after the cycle's outputs have been sampled.
    task automatic drive(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            seg = p;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg = 8'h00;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] illegal [5];
        illegal = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08};

        @(negedge clk);
        #1;
        rst = 1'b0;
        check("rst_digit", int'(if0.digit), 0);
        check("rst_valid", int'(if0.digit_valid), 0);
        check("rst_locked", int'(if0.locked), 0);
        check("rst_err", int'(if0.err_cnt), 0);

        // Full 0..9 wrap back to 0, one pattern per cycle
        base = dv_cnt[0];
        for (int i = 0; i < 10; i++) drive(codes[i], 1);
        drive(8'hFC, 1);
        check("t1_pulses", dv_cnt[0] - base, 11);
        check("t1_digit", int'(if0.digit), 0);
        check("t1_locked", int'(if0.locked), 1);
        check("t1_err", int'(if0.err_cnt), 0);

        // Debounce with STABLE_CYCLES=3
        do_reset();
        base = dv_cnt[1];
        drive(8'h60, 2);
        drive(8'hDA, 2);
        check("t2_no_pulse", dv_cnt[1] - base, 0);
        drive(8'hDA, 1);
        check("t2_valid", int'(if1.digit_valid), 1);
        check("t2_digit", int'(if1.digit), 2);
        drive(8'hDA, 1);
        check("t2_once", int'(if1.digit_valid), 0);

        // Sequence break then silent resync
        do_reset();
        drive(8'hFC, 1);
        drive(8'h60, 1);
        drive(8'hDA, 1);
        drive(8'hB6, 1);
        check("t3_seq", int'(if0.seq_err), 1);
        check("t3_digit", int'(if0.digit), 5);
        check("t3_err", int'(if0.err_cnt), 1);
        check("t3_unlocked", int'(if0.locked), 0);
        drive(8'hBE, 1);
        check("t3_resync_valid", int'(if0.digit_valid), 1);
        check("t3_resync_seq", int'(if0.seq_err), 0);
        check("t3_relocked", int'(if0.locked), 1);

        // Illegal code in tracking, blank, then dp-tagged zero
        drive(8'h81, 1);
        check("t4_bad", int'(if0.bad_code), 1);
        check("t4_err", int'(if0.err_cnt), 2);
        check("t4_digit_hold", int'(if0.digit), 6);
        check("t4_unlocked", int'(if0.locked), 0);
        drive(8'h00, 1);
        check("t4_blank_nopulse", int'(if0.digit_valid), 0);
        drive(8'hFD, 1);
        check("t4_dp_valid", int'(if0.digit_valid), 1);
        check("t4_dp_digit", int'(if0.digit), 0);
        check("t4_dp_locked", int'(if0.locked), 1);

        // Saturating 2-bit error counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(illegal[i], 1);
            check($sformatf("t5_err%0d", i), int'(if2.err_cnt), (i < 3) ? i + 1 : 3);
        end

        // Reset mid-sequence
        do_reset();
        for (int i = 0; i < 8; i++) drive(codes[i], 1);
        check("t6_pre_digit", int'(if0.digit), 7);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_digit", int'(if0.digit), 0);
        check("t6_rst_locked", int'(if0.locked), 0);
        check("t6_rst_valid", int'(if0.digit_valid), 0);
        drive(8'hF2, 1);
        check("t6_valid", int'(if0.digit_valid), 1);
        check("t6_digit", int'(if0.digit), 3);
        check("t6_no_seq", int'(if0.seq_err), 0);
        check("t6_err", int'(if0.err_cnt), 0);

        drive(8'hF2, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
